store_merge: RTL
================

STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  store request valid.
REQ-005 SHALL have port req_ready  output  1  block idle; request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_op  input  2  store width: 00 sw, 01 sh, 10 sb, 11 reserved (treated as sw).
REQ-007 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data; sh uses [15:0], sb uses [7:0].
REQ-009 SHALL have port done  output  1  one-cycle pulse on store completion.
REQ-010 SHALL have port misalign  output  1  one-cycle pulse on a rejected misaligned request.
REQ-011 SHALL have port mem_addr  output  ADDR_W  word-aligned address, [1:0] always 00.
REQ-012 SHALL have port mem_rd_en  output  1  memory read strobe; mem_rdata valid on the next cycle.
REQ-013 SHALL have port mem_rdata  input  32  memory read word.
REQ-014 SHALL have port mem_wr_en  output  1  memory full-word write strobe.
REQ-015 SHALL have port mem_wdata  output  32  merged word to write.

Function
REQ-016 SHALL implement states IDLE, READ, MERGE, WRITE; req_ready = 1 only in IDLE.
REQ-017 SHALL register req_op, aligned address and req_wdata on acceptance; input changes afterwards have no effect.
REQ-018 SHALL, for sw accepted at cycle T, go IDLE->WRITE, drive mem_wr_en=1 with mem_wdata=req_wdata at T+1, and pulse done at T+1.
REQ-019 SHALL, for sh/sb accepted at T, assert mem_rd_en at T+1 (READ), capture mem_rdata at T+2 (MERGE), assert mem_wr_en at T+3 (WRITE), and pulse done at T+3.
REQ-020 SHALL use little-endian byte lanes: sb lane = addr[1:0] (lane 0 = bits [7:0]); sh lane = addr[1] (0 = [15:0], 1 = [31:16]).
REQ-021 SHALL replace only the selected lane with the low byte/halfword of the stored data and keep all other bits of mem_rdata unchanged.
REQ-022 SHALL hold mem_rd_en and mem_wr_en to exactly one cycle each per store; both SHALL never be high together.
REQ-023 SHALL return to IDLE in the cycle after WRITE; a new request SHALL be acceptable in that cycle (back-to-back sw: one store per 2 cycles).
REQ-024 SHALL ignore req_valid while req_ready=0; no request is queued.
REQ-025 SHALL drive mem_addr = stored address with [1:0] forced to 00 in READ and WRITE, and 0 otherwise.

Reset
REQ-026 SHALL, on reset, immediately enter IDLE and drive req_ready=1 and done, misalign, mem_rd_en, mem_wr_en, mem_addr, mem_wdata = 0.
REQ-027 SHALL, if reset asserts mid-store, abort the store with no subsequent mem_wr_en and no done pulse.
REQ-028 SHALL accept requests beginning with the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL support macro STORE_MISALIGN_CHECK_EN.
REQ-030 SHALL, with STORE_MISALIGN_CHECK_EN defined, reject sw with addr[1:0]!=0 and sh with addr[0]!=0: stay in IDLE, pulse misalign for one cycle, no memory access, no done.
REQ-031 SHALL, without the macro, silently ignore misaligned low bits (sw aligns to word, sh uses addr[1]), and tie misalign to 0.

Verification
REQ-032 SHALL verify: sw addr=0x10, wdata=0xDEADBEEF -> next cycle mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never high.
REQ-033 SHALL verify: sb addr=0x23, wdata=0x000000AA, mem_rdata=0x11223344 -> mem_rd_en at T+1 with mem_addr=0x20; write at T+3 with mem_wdata=0xAA223344.
REQ-034 SHALL verify: sh addr=0x42, wdata=0x0000BEEF, mem_rdata=0x11223344 -> mem_wdata=0xBEEF3344 at T+3.
REQ-035 SHALL verify: sw addr=0x13 -> with macro: misalign pulse, no mem strobes; without macro: write to 0x10.
REQ-036 SHALL verify: reset asserted in MERGE of an sb -> outputs 0 asynchronously, no mem_wr_en and no done afterwards; req_ready=1.
REQ-037 SHALL verify: req_valid held high across an sh -> second store accepted only once req_ready returns to 1; exactly two write strobes.

Source files
------------

// File: rtl/store_merge.sv
// rtl/store_merge.sv - sub-word store merge engine (read-modify-write for sh/sb)
//
// Purpose: accepts one store at a time. A full-word store (sw) is written
// immediately. A halfword (sh) or byte (sb) store reads the containing word,
// replaces the selected little-endian lane and writes the merged word back.
//
// Optional feature: define STORE_MISALIGN_CHECK_EN to reject misaligned sw/sh
// requests with a one-cycle misalign pulse instead of silently aligning them.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   store request valid
//   req_ready  out  high only when idle; accept = req_valid && req_ready
//   req_op     in   00 sw, 01 sh, 10 sb, 11 reserved (treated as sw)
//   req_addr   in   byte address
//   req_wdata  in   store data (sh uses [15:0], sb uses [7:0])
//   done       out  one-cycle pulse on store completion
//   misalign   out  one-cycle pulse on a rejected misaligned request
//   mem_addr   out  word-aligned address during READ/WRITE, 0 otherwise
//   mem_rd_en  out  read strobe; mem_rdata is valid the following cycle
//   mem_rdata  in   memory read word
//   mem_wr_en  out  full-word write strobe
//   mem_wdata  out  word to write

module store_merge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef STORE_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  logic              req_is_sw;
  logic              req_is_sh;
  logic              reject;
  logic [ADDR_W-1:0] req_addr_aligned;
  logic [31:0]       merged;

  assign req_is_sw        = (req_op == 2'b00) || (req_op == 2'b11);
  assign req_is_sh        = (req_op == 2'b01);
  assign req_addr_aligned = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_MISALIGN_CHECK_EN
  assign reject = (req_is_sw && (req_addr[1:0] != 2'b00)) || (req_is_sh && req_addr[0]);
`else
  assign reject = 1'b0;
`endif

  // Lane replacement on the word read back; only the selected lane changes.
  always_comb begin
    merged = mem_rdata;
    if (op_q == 2'b01) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
`ifdef STORE_MISALIGN_CHECK_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reject) begin
`ifdef STORE_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            op_d       = req_op;
            addr_d     = req_addr_aligned;
            lane_d     = req_addr[1:0];
            wdata_d    = req_wdata[15:0];
            mem_addr_d = req_addr_aligned;
            if (req_is_sw) begin
              // Full word: no read needed, write straight away.
              state_d     = WRITE;
              wr_en_d     = 1'b1;
              done_d      = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = READ;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      READ: begin
        // Read strobe was this cycle; data arrives during MERGE.
        state_d = MERGE;
      end
      MERGE: begin
        state_d     = WRITE;
        wr_en_d     = 1'b1;
        done_d      = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = merged;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= '0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef STORE_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef STORE_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef STORE_MISALIGN_CHECK_EN
  assign misalign  = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule
